// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
// Per-lane receive deserializer. It shifts in an MSB-first serial bitstream
// at clk_32f and searches bit by bit for the COM symbol to find byte
// alignment. After COM_REQ aligned COMs the lane is locked ('active'). From
// then on, every byte boundary that does not carry COM delivers one data byte
// with a one-cycle valid strobe.
//
// Optional feature macro: SERIAL_RX_CNT_EN
//   defined   -> byte_count port plus a 16-bit saturating count of delivered
//                data bytes, cleared only by reset
//   undefined -> no byte_count port and no counter
// ---------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned COM_REQ    = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
`ifdef SERIAL_RX_CNT_EN
    output logic [15:0] byte_count,
`endif
    output logic        active
);

    // Lock threshold as a 4-bit value; the legal range is 1..15.
    localparam logic [3:0] COM_REQ_C = COM_REQ[3:0];

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  sr_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  com_cnt_q;
    logic [7:0]  data_out_q;
    logic        valid_out_q;
    logic        active_q;

    logic [7:0]  sr_d;
    logic [3:0]  com_cnt_inc_d;
    logic        com_match_s;
    logic        boundary_s;
    logic        deliver_s;

    // Next shift-register value, match and boundary decode, and the delivery condition.
    always_comb begin
        sr_d          = {sr_q[6:0], data_in};
        com_cnt_inc_d = com_cnt_q + 4'd1;
        com_match_s   = (sr_q == COM_SYMBOL);
        // In HUNT the bit counter is frozen, so boundaries only exist once aligned.
        boundary_s    = (bit_cnt_q == 3'd0) && (state_q != ST_HUNT);
        if ((state_q == ST_ACTIVE) && boundary_s && !com_match_s) begin
            deliver_s = 1'b1;
        end else begin
            deliver_s = 1'b0;
        end
    end

    // Alignment FSM, shift register and registered outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            com_cnt_q   <= 4'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            // The shift register runs in every state; alignment is only a view on it.
            sr_q        <= sr_d;
            // The strobe is high for a single cycle unless a delivery happens below.
            valid_out_q <= 1'b0;

            case (state_q)
                ST_HUNT: begin
                    // Bit-sliding search: any cycle may hold the COM symbol.
                    if (com_match_s) begin
                        // This edge already samples the first bit of the next byte.
                        bit_cnt_q <= 3'd1;
                        com_cnt_q <= 4'd1;
                        if (COM_REQ_C == 4'd1) begin
                            state_q  <= ST_ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q  <= ST_ALIGN;
                        end
                    end else begin
                        bit_cnt_q <= 3'd0;
                    end
                end

                ST_ALIGN: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary_s) begin
                        if (com_match_s) begin
                            com_cnt_q <= com_cnt_inc_d;
                            if (com_cnt_inc_d == COM_REQ_C) begin
                                state_q  <= ST_ACTIVE;
                                active_q <= 1'b1;
                            end else begin
                                state_q  <= ST_ALIGN;
                            end
                        end else begin
                            // Alignment came from a false COM; drop it and search again.
                            state_q   <= ST_HUNT;
                            com_cnt_q <= 4'd0;
                            bit_cnt_q <= 3'd0;
                        end
                    end else begin
                        state_q <= ST_ALIGN;
                    end
                end

                ST_ACTIVE: begin
                    // Locked: only reset leaves this state, there is no loss-of-lock check.
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (deliver_s) begin
                        data_out_q  <= sr_q;
                        valid_out_q <= 1'b1;
                    end else begin
                        data_out_q  <= data_out_q;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean search.
                    state_q   <= ST_HUNT;
                    bit_cnt_q <= 3'd0;
                    com_cnt_q <= 4'd0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_RX_CNT_EN
    logic [15:0] byte_count_q;

    // Saturating count of delivered data bytes; advances on the same edge that raises valid_out.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            byte_count_q <= 16'h0000;
        end else if (deliver_s && (byte_count_q != 16'hFFFF)) begin
            byte_count_q <= byte_count_q + 16'h0001;
        end else begin
            byte_count_q <= byte_count_q;
        end
    end

    assign byte_count = byte_count_q;
`endif

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Directed bench for serial_paralelo_rx. Data bytes that must come out are
// pushed to a scoreboard queue when they are driven. Each valid_out strobe
// pops the queue and compares the popped byte with data_out.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
`ifdef SERIAL_RX_CNT_EN
    logic [15:0] byte_count;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          vcyc[$];
    int          tcyc;
    logic        prev_valid;
    logic        first_seen;
    logic        first_active;
    logic        first_valid;
    logic [7:0]  first_data;
    logic        act_after_first;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
`ifdef SERIAL_RX_CNT_EN
        .byte_count(byte_count),
`endif
        .active    (active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one serial bit, then sample the outputs 1 time unit after the edge.
    task automatic step(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        tcyc++;
        if (!first_seen) begin
            first_seen   = 1'b1;
            first_active = active;
            first_valid  = valid_out;
            first_data   = data_out;
        end
        if (valid_out === 1'b1) begin
            chk("valid_gap", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_valid: observed data %0h, expected no strobe", data_out);
            end else begin
                chk("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
            vcyc.push_back(tcyc);
        end
        prev_valid = valid_out;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic push);
        if (push) exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            step(b[i]);
            if (i == 7) act_after_first = active;
        end
    endtask

    task automatic clear_track();
        tcyc       = 0;
        prev_valid = 1'b0;
        first_seen = 1'b0;
        exp_q.delete();
        vcyc.delete();
    endtask

    task automatic do_reset(input int ncyc, input logic check);
        reset = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            step(1'(i % 2));
            if (check) begin
                chk("rst_data_out", {24'd0, data_out}, 32'h00);
                chk("rst_valid", {31'd0, valid_out}, 32'd0);
                chk("rst_active", {31'd0, active}, 32'd0);
            end
        end
        reset = 1'b0;
        clear_track();
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hBC, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        clear_track();

        // Test 1 + 2: reset with toggling input, then aligned stream from bit 0.
        do_reset(3, 1'b1);
        send_coms(4);
        chk("t1_first_active", {31'd0, first_active}, 32'd0);
        chk("t1_first_valid", {31'd0, first_valid}, 32'd0);
        chk("t1_first_data", {24'd0, first_data}, 32'h00);
        chk("t2_active_before", {31'd0, active}, 32'd0);
        send_byte(8'hA5, 1'b1);
        chk("t2_active_rise", {31'd0, act_after_first}, 32'd1);
        send_byte(8'h3C, 1'b1);
        send_coms(2);
        chk("t2_npulses", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) begin
            chk("t2_cyc0", vcyc[0], 32'd41);
            chk("t2_cyc1", vcyc[1], 32'd49);
        end
        chk("t2_sb_empty", exp_q.size(), 32'd0);
        chk("t2_data_hold", {24'd0, data_out}, 32'h3C);

        // Test 3: three random prefix bits shift everything by 3 cycles.
        do_reset(3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1, 0)));
        send_coms(4);
        chk("t3_active_before", {31'd0, active}, 32'd0);
        send_byte(8'hA5, 1'b1);
        chk("t3_active_rise", {31'd0, act_after_first}, 32'd1);
        send_byte(8'h3C, 1'b1);
        send_coms(2);
        chk("t3_npulses", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) begin
            chk("t3_cyc0", vcyc[0], 32'd44);
            chk("t3_cyc1", vcyc[1], 32'd52);
        end
        chk("t3_sb_empty", exp_q.size(), 32'd0);

        // Test 4: ALIGN aborts at 8'h11, re-hunt locks on the last four COMs.
        do_reset(3, 1'b0);
        send_coms(2);
        send_byte(8'h11, 1'b0);
        chk("t4_active_after_11", {31'd0, active}, 32'd0);
        send_coms(4);
        chk("t4_active_before", {31'd0, active}, 32'd0);
        send_byte(8'h5A, 1'b1);
        chk("t4_active_rise", {31'd0, act_after_first}, 32'd1);
        send_coms(2);
        chk("t4_npulses", vcyc.size(), 32'd1);
        if (vcyc.size() == 1) chk("t4_cyc0", vcyc[0], 32'd65);
        chk("t4_sb_empty", exp_q.size(), 32'd0);

        // Test 5: COM bytes inside ACTIVE produce no strobe and data_out holds.
        do_reset(3, 1'b0);
        send_coms(4);
        send_byte(8'h77, 1'b1);
        send_coms(2);
        chk("t5_hold_77", {24'd0, data_out}, 32'h77);
        chk("t5_npulses_mid", vcyc.size(), 32'd1);
        send_byte(8'h88, 1'b1);
        send_coms(2);
        chk("t5_npulses", vcyc.size(), 32'd2);
        chk("t5_data_88", {24'd0, data_out}, 32'h88);
        chk("t5_sb_empty", exp_q.size(), 32'd0);

        // Test 6: one-cycle reset in the middle of a data byte, then relock.
        do_reset(3, 1'b0);
        send_coms(4);
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) step(1'(i % 2));
        chk("t6_active_pre", {31'd0, active}, 32'd1);
`ifdef SERIAL_RX_CNT_EN
        chk("t6_count_pre", {16'd0, byte_count}, 32'd1);
`endif
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        chk("t6_active_rst", {31'd0, active}, 32'd0);
        chk("t6_valid_rst", {31'd0, valid_out}, 32'd0);
`ifdef SERIAL_RX_CNT_EN
        chk("t6_count_rst", {16'd0, byte_count}, 32'd0);
`endif
        chk("t6_sb_empty_pre", exp_q.size(), 32'd0);
        clear_track();
        send_coms(3);
        chk("t6_active_3com", {31'd0, active}, 32'd0);
        send_coms(1);
        chk("t6_active_4com", {31'd0, active}, 32'd0);
        send_byte(8'h96, 1'b1);
        chk("t6_active_rise", {31'd0, act_after_first}, 32'd1);
        send_coms(2);
        chk("t6_npulses", vcyc.size(), 32'd1);
        chk("t6_sb_empty", exp_q.size(), 32'd0);
`ifdef SERIAL_RX_CNT_EN
        chk("t6_count_post", {16'd0, byte_count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
